// File: rtl/level_latch_checker_pkg.sv
// Shared definitions for the level-sensitive latch protocol checker:
// FSM state encodings and the largest supported din->dout settling delay.
package level_latch_checker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_TRANSP = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

  localparam int LAT_DLY_MAX = 3;

endpackage

// File: rtl/level_latch_checker_lat_edge_det.sv
// Edge detector for the observed latch enable: keeps the previous-cycle
// sample of the enable and derives single-cycle rise/fall strobes from it.
module lat_edge_det (
  input  logic clk,
  input  logic reset,
  input  logic i_en,
  output logic o_rise,
  output logic o_fall
);

  logic r_en_q;

  // Previous-cycle copy of the enable; cleared so a high enable after reset reads as a rise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_en_q <= 1'b0;
    end else begin
      r_en_q <= i_en;
    end
  end

  assign o_rise = i_en & ~r_en_q;
  assign o_fall = ~i_en & r_en_q;

endmodule

// File: rtl/level_latch_checker.sv
// Reader-side protocol checker for a positive-level latch. Samples the latch
// enable, input and output on the system clock, checks that the output follows
// the (optionally delayed) input while transparent and stays frozen while
// closed, and reports violations as a pulse, a sticky flag and two saturating
// counters.
module level_latch_checker
  import level_latch_checker_pkg::*;
#(
  parameter int WIDTH   = 1,
  parameter int LAT_DLY = 0,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             lat_en,
  input  logic [WIDTH-1:0] lat_din,
  input  logic [WIDTH-1:0] lat_dout,
  output logic             err_pulse,
  output logic             err_any,
  output logic [CNT_W-1:0] err_transp_cnt,
  output logic [CNT_W-1:0] err_hold_cnt,
  output logic [WIDTH-1:0] hold_ref,
  output logic [1:0]       state
);

  // Last settling cycle index; only meaningful when LAT_DLY > 0.
  localparam logic [1:0] SETTLE_LAST = (LAT_DLY == 0) ? 2'd0 : 2'(LAT_DLY - 1);
  // A rising enable skips the settling window entirely when no delay is allowed.
  localparam state_t RISE_TARGET = (LAT_DLY == 0) ? ST_TRANSP : ST_SETTLE;

  logic             w_rise;
  logic             w_fall;
  logic [WIDTH-1:0] w_din_d;
  logic [WIDTH-1:0] r_din_q;
  state_t           r_state;
  state_t           w_state_next;
  logic [1:0]       r_dly_cnt;
  logic [1:0]       w_dly_cnt_next;
  logic [WIDTH-1:0] r_hold_ref;
  logic [WIDTH-1:0] w_hold_ref_next;
  logic             w_transp_viol;
  logic             w_hold_viol;
  logic             w_viol;
  logic             r_err_pulse;
  logic             r_err_any;
  logic [CNT_W-1:0] r_transp_cnt;
  logic [CNT_W-1:0] r_hold_cnt;

  lat_edge_det u_edge (
    .clk    (clk),
    .reset  (reset),
    .i_en   (lat_en),
    .o_rise (w_rise),
    .o_fall (w_fall)
  );

  // One-cycle-old input: the last value the latch saw before a falling enable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_din_q <= '0;
    end else begin
      r_din_q <= lat_din;
    end
  end

  // Reference for the transparent check: input delayed by the allowed latch latency.
  if (LAT_DLY == 0) begin : g_no_dly
    assign w_din_d = lat_din;
  end else begin : g_dly
    logic [WIDTH-1:0] r_dly [LAT_DLY];

    // Shift register of past inputs, newest in stage 0.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        for (int k = 0; k < LAT_DLY; k++) begin
          r_dly[k] <= '0;
        end
      end else begin
        r_dly[0] <= lat_din;
        for (int k = 1; k < LAT_DLY; k++) begin
          r_dly[k] <= r_dly[k-1];
        end
      end
    end

    assign w_din_d = r_dly[LAT_DLY-1];
  end

  // FSM state register together with its settle counter and held-value reference.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_dly_cnt  <= 2'd0;
      r_hold_ref <= '0;
    end else begin
      r_state    <= w_state_next;
      r_dly_cnt  <= w_dly_cnt_next;
      r_hold_ref <= w_hold_ref_next;
    end
  end

  // Next-state: enable edges move between phases, the settle window times out into TRANSP.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE, ST_HOLD: begin
        if (w_rise) w_state_next = RISE_TARGET;
      end
      ST_SETTLE: begin
        if (w_fall)                         w_state_next = ST_HOLD;
        else if (r_dly_cnt == SETTLE_LAST)  w_state_next = ST_TRANSP;
      end
      ST_TRANSP: begin
        if (w_fall) w_state_next = ST_HOLD;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Per-state checks and bookkeeping; the rise cycle itself is never checked.
  always_comb begin
    w_transp_viol   = 1'b0;
    w_hold_viol     = 1'b0;
    w_dly_cnt_next  = r_dly_cnt;
    w_hold_ref_next = r_hold_ref;
    case (r_state)
      ST_IDLE: begin
        if (w_rise) w_dly_cnt_next = 2'd0;
      end
      ST_SETTLE: begin
        w_dly_cnt_next = r_dly_cnt + 2'd1;
        if (w_fall) w_hold_ref_next = r_din_q;
      end
      ST_TRANSP: begin
        if (lat_en) begin
          w_transp_viol = (lat_dout != w_din_d);
        end else begin
          // Falling cycle: the output must already equal the last transparent input.
          w_hold_ref_next = r_din_q;
          w_hold_viol     = (lat_dout != r_din_q);
        end
      end
      ST_HOLD: begin
        if (w_rise)       w_dly_cnt_next = 2'd0;
        else if (!lat_en) w_hold_viol    = (lat_dout != r_hold_ref);
      end
      default: ;
    endcase
  end

  assign w_viol = w_transp_viol | w_hold_viol;

  // Error reporting: pulse always follows a violation; clr overrides counters and sticky flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_err_pulse  <= 1'b0;
      r_err_any    <= 1'b0;
      r_transp_cnt <= '0;
      r_hold_cnt   <= '0;
    end else begin
      r_err_pulse <= w_viol;
      if (clr) begin
        r_err_any    <= 1'b0;
        r_transp_cnt <= '0;
        r_hold_cnt   <= '0;
      end else begin
        if (w_viol)                        r_err_any    <= 1'b1;
        if (w_transp_viol && !(&r_transp_cnt)) r_transp_cnt <= r_transp_cnt + 1'b1;
        if (w_hold_viol && !(&r_hold_cnt))     r_hold_cnt   <= r_hold_cnt + 1'b1;
      end
    end
  end

  assign err_pulse      = r_err_pulse;
  assign err_any        = r_err_any;
  assign err_transp_cnt = r_transp_cnt;
  assign err_hold_cnt   = r_hold_cnt;
  assign hold_ref       = r_hold_ref;
  assign state          = r_state;

endmodule

// File: tb/tb_level_latch_checker.sv
// Directed bench for level_latch_checker: one instance with no latch delay and
// 2-bit counters (saturation, clear, reset cases) and one with a 2-cycle delay.
`timescale 1ns/1ps
module tb_level_latch_checker;

  logic clk;
  logic reset;

  // Instance A: WIDTH=1, LAT_DLY=0, CNT_W=2
  logic       a_clr, a_en, a_din, a_dout;
  logic       a_pulse, a_any, a_href;
  logic [1:0] a_tcnt, a_hcnt, a_state;

  // Instance B: WIDTH=1, LAT_DLY=2, CNT_W=8
  logic       b_clr, b_en, b_din, b_dout;
  logic       b_pulse, b_any, b_href;
  logic [7:0] b_tcnt, b_hcnt;
  logic [1:0] b_state;

  int n_cmp = 0;
  int n_bad = 0;

  level_latch_checker #(.WIDTH(1), .LAT_DLY(0), .CNT_W(2)) u_dut_a (
    .clk(clk), .reset(reset), .clr(a_clr), .lat_en(a_en), .lat_din(a_din),
    .lat_dout(a_dout), .err_pulse(a_pulse), .err_any(a_any),
    .err_transp_cnt(a_tcnt), .err_hold_cnt(a_hcnt), .hold_ref(a_href), .state(a_state)
  );

  level_latch_checker #(.WIDTH(1), .LAT_DLY(2), .CNT_W(8)) u_dut_b (
    .clk(clk), .reset(reset), .clr(b_clr), .lat_en(b_en), .lat_din(b_din),
    .lat_dout(b_dout), .err_pulse(b_pulse), .err_any(b_any),
    .err_transp_cnt(b_tcnt), .err_hold_cnt(b_hcnt), .hold_ref(b_href), .state(b_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs to A at a falling edge; returns at the next falling edge.
  task automatic cyc_a(input logic en, input logic din, input logic dout, input logic c);
    a_en = en; a_din = din; a_dout = dout; a_clr = c;
    @(posedge clk);
    @(negedge clk);
    $display("A en=%0d din=%0d dout=%0d clr=%0d -> pulse=%0d any=%0d tcnt=%0d hcnt=%0d href=%0d st=%0d",
             en, din, dout, c, a_pulse, a_any, a_tcnt, a_hcnt, a_href, a_state);
  endtask

  task automatic cyc_b(input logic en, input logic din, input logic dout);
    b_en = en; b_din = din; b_dout = dout; b_clr = 1'b0;
    @(posedge clk);
    @(negedge clk);
    $display("B en=%0d din=%0d dout=%0d -> pulse=%0d any=%0d tcnt=%0d hcnt=%0d st=%0d",
             en, din, dout, b_pulse, b_any, b_tcnt, b_hcnt, b_state);
  endtask

  initial begin
    logic       held;
    logic       en, din, dout;
    logic       hist [64];
    logic [27:0] pat;
    int         lag;
    int         exp_cnt;
    logic       viol;

    reset = 1'b1;
    a_clr = 1'b0; a_en = 1'b0; a_din = 1'b0; a_dout = 1'b0;
    b_clr = 1'b0; b_en = 1'b0; b_din = 1'b0; b_dout = 1'b0;
    @(negedge clk);
    @(negedge clk);

    // Reset state
    check("rst_pulse", 32'(a_pulse), 0);
    check("rst_any",   32'(a_any),   0);
    check("rst_tcnt",  32'(a_tcnt),  0);
    check("rst_hcnt",  32'(a_hcnt),  0);
    check("rst_href",  32'(a_href),  0);
    check("rst_state", 32'(a_state), 0);
    check("rst_b_state", 32'(b_state), 0);
    reset = 1'b0;

    // Test 4: LAT_DLY=2; lag 2 is legal, lag 3 mismatches wherever din changed.
    pat = 28'b1011_0010_1110_0100_1101_0011_0110;
    exp_cnt = 0;
    for (int t = 0; t < 28; t++) begin
      hist[t] = pat[t];
      lag = (t < 14) ? 2 : 3;
      dout = (t >= lag) ? hist[t-lag] : 1'b0;
      // State is TRANSP from t=3 on (rise at t=0, two settle cycles); ref is din[t-2].
      viol = (t >= 3) && (dout != hist[t-2]);
      if (viol) exp_cnt++;
      cyc_b(1'b1, hist[t], dout);
      check("b_pulse", 32'(b_pulse), 32'(viol));
    end
    check("b_tcnt", 32'(b_tcnt), 32'(exp_cnt));
    check("b_hcnt", 32'(b_hcnt), 0);
    check("b_any",  32'(b_any),  32'(exp_cnt != 0));
    cyc_b(1'b0, 1'b0, 1'b0);

    // Test 1: ideal latch, random din, enable period of 4 clocks -> no errors.
    held = 1'b0;
    for (int i = 0; i < 48; i++) begin
      en   = 1'((i >> 1) & 1);
      din  = 1'($urandom_range(0, 1));
      dout = en ? din : held;
      if (en) held = din;
      cyc_a(en, din, dout, 1'b0);
      check("t1_pulse", 32'(a_pulse), 0);
    end
    check("t1_tcnt", 32'(a_tcnt), 0);
    check("t1_hcnt", 32'(a_hcnt), 0);
    check("t1_any",  32'(a_any),  0);

    // Test 2: one transparent mismatch.
    cyc_a(1'b1, 1'b0, 1'b0, 1'b0);
    check("t2_pre_pulse", 32'(a_pulse), 0);
    cyc_a(1'b1, 1'b1, 1'b0, 1'b0);
    check("t2_pulse", 32'(a_pulse), 1);
    check("t2_tcnt",  32'(a_tcnt),  1);
    check("t2_any",   32'(a_any),   1);
    cyc_a(1'b1, 1'b1, 1'b1, 1'b0);
    check("t2_pulse_drop", 32'(a_pulse), 0);
    check("t2_tcnt_keep",  32'(a_tcnt),  1);

    // Test 3: fall with din=1, dout drops two cycles later.
    cyc_a(1'b0, 1'b0, 1'b1, 1'b0);
    check("t3_fall_pulse", 32'(a_pulse), 0);
    check("t3_href",       32'(a_href),  1);
    check("t3_state",      32'(a_state), 3);
    cyc_a(1'b0, 1'b1, 1'b1, 1'b0);
    check("t3_hold_pulse", 32'(a_pulse), 0);
    cyc_a(1'b0, 1'b0, 1'b0, 1'b0);
    check("t3_pulse", 32'(a_pulse), 1);
    check("t3_hcnt",  32'(a_hcnt),  1);
    cyc_a(1'b0, 1'b0, 1'b1, 1'b0);
    check("t3_pulse_drop", 32'(a_pulse), 0);

    // Test 6: reset mid-HOLD with dout wrong.
    cyc_a(1'b0, 1'b0, 1'b0, 1'b0);
    check("t6_pre_pulse", 32'(a_pulse), 1);
    check("t6_pre_hcnt",  32'(a_hcnt),  2);
    reset = 1'b1;
    #1;
    check("t6_rst_pulse", 32'(a_pulse), 0);
    check("t6_rst_any",   32'(a_any),   0);
    check("t6_rst_tcnt",  32'(a_tcnt),  0);
    check("t6_rst_hcnt",  32'(a_hcnt),  0);
    check("t6_rst_href",  32'(a_href),  0);
    check("t6_rst_state", 32'(a_state), 0);
    @(negedge clk);
    reset = 1'b0;
    cyc_a(1'b0, 1'b1, 1'b0, 1'b0);
    check("t6_idle_pulse", 32'(a_pulse), 0);
    check("t6_idle_state", 32'(a_state), 0);
    cyc_a(1'b1, 1'b1, 1'b0, 1'b0);
    check("t6_rise_pulse", 32'(a_pulse), 0);
    check("t6_rise_state", 32'(a_state), 2);
    cyc_a(1'b1, 1'b1, 1'b0, 1'b0);
    check("t6_resume_pulse", 32'(a_pulse), 1);
    check("t6_resume_tcnt",  32'(a_tcnt),  1);

    // Test 5: CNT_W=2 saturation, then clr coincident with a violation.
    cyc_a(1'b1, 1'b1, 1'b1, 1'b0);
    cyc_a(1'b0, 1'b0, 1'b1, 1'b0);
    check("t5_fall_pulse", 32'(a_pulse), 0);
    check("t5_href",       32'(a_href),  1);
    for (int k = 1; k <= 5; k++) begin
      cyc_a(1'b0, 1'b0, 1'b0, 1'b0);
      check("t5_pulse", 32'(a_pulse), 1);
      check("t5_hcnt",  32'(a_hcnt),  32'((k > 3) ? 3 : k));
    end
    cyc_a(1'b0, 1'b0, 1'b0, 1'b1);
    check("t5_clr_pulse", 32'(a_pulse), 1);
    check("t5_clr_hcnt",  32'(a_hcnt),  0);
    check("t5_clr_tcnt",  32'(a_tcnt),  0);
    check("t5_clr_any",   32'(a_any),   0);
    cyc_a(1'b0, 1'b0, 1'b1, 1'b0);
    check("t5_post_pulse", 32'(a_pulse), 0);
    check("t5_post_any",   32'(a_any),   0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
